// File: rtl/demux_32_1_2_buf.sv
// Registered 1-to-2 demultiplexer: each input word is steered by Sel into one of
// two independent FIFOs (A/B), each drained through its own valid/ready port.

module demux_32_1_2_buf_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop_req,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic [AW:0]      cnt
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             pop;

  // Popping an empty FIFO is ignored so the count can never underflow.
  assign pop   = pop_req && valid;
  assign valid = (cnt_q != '0);
  assign full  = (cnt_q == FULL_CNT);
  assign cnt   = cnt_q;
  assign dout  = valid ? mem[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is left unreset; dout is gated by valid so stale words never leak out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end

endmodule

module demux_32_1_2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] I,
  input  logic             Sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] OA,
  output logic             OA_valid,
  input  logic             OA_ready,
  output logic [WIDTH-1:0] OB,
  output logic             OB_valid,
  input  logic             OB_ready,
  output logic [AW:0]      cnt_a,
  output logic [AW:0]      cnt_b
);

  logic full_a, full_b;
  logic push_a, push_b;

  // Readiness depends only on Sel and registered counts, never on the consumer readies.
  assign in_ready = Sel ? !full_b : !full_a;
  assign push_a   = in_valid && in_ready && !Sel;
  assign push_b   = in_valid && in_ready &&  Sel;

  demux_32_1_2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_fifo_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_a),
    .pop_req (OA_ready),
    .din     (I),
    .dout    (OA),
    .valid   (OA_valid),
    .full    (full_a),
    .cnt     (cnt_a)
  );

  demux_32_1_2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_fifo_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_b),
    .pop_req (OB_ready),
    .din     (I),
    .dout    (OB),
    .valid   (OB_valid),
    .full    (full_b),
    .cnt     (cnt_b)
  );

endmodule

// File: tb/tb_demux_32_1_2_buf.sv
// Self-checking bench for demux_32_1_2_buf: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.

module tb_demux_32_1_2_buf;

  localparam int DEPTH = 2;
  localparam int AW    = 1;

  logic          clk;
  logic          rst_n;
  logic [31:0]   I;
  logic          Sel;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   OA;
  logic          OA_valid;
  logic          OA_ready;
  logic [31:0]   OB;
  logic          OB_valid;
  logic          OB_ready;
  logic [AW:0]   cnt_a;
  logic [AW:0]   cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  demux_32_1_2_buf #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .I        (I),
    .Sel      (Sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .OA       (OA),
    .OA_valid (OA_valid),
    .OA_ready (OA_ready),
    .OB       (OB),
    .OB_valid (OB_valid),
    .OB_ready (OB_ready),
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready(input logic s);
    return s ? (qb.size() != DEPTH) : (qa.size() != DEPTH);
  endfunction

  // Every output is compared against what the two queues say it must be.
  task automatic checkOutput();
    chk("in_ready", 64'(in_ready), 64'(model_ready(Sel)));
    chk("OA_valid", 64'(OA_valid), 64'(qa.size() != 0));
    chk("OA",       64'(OA),       64'((qa.size() != 0) ? qa[0] : 32'h0));
    chk("cnt_a",    64'(cnt_a),    64'(qa.size()));
    chk("OB_valid", 64'(OB_valid), 64'(qb.size() != 0));
    chk("OB",       64'(OB),       64'((qb.size() != 0) ? qb[0] : 32'h0));
    chk("cnt_b",    64'(cnt_b),    64'(qb.size()));
  endtask

  // Called at a negedge; drives one cycle, checks, advances the model across the posedge.
  task automatic applyStimulus(input logic v, input logic s, input logic [31:0] d,
                               input logic ra, input logic rb);
    bit push_a, push_b, pop_a, pop_b;
    in_valid = v;
    Sel      = s;
    I        = d;
    OA_ready = ra;
    OB_ready = rb;
    #1;
    checkOutput();
    push_a = v && !s && (qa.size() < DEPTH);
    push_b = v &&  s && (qb.size() < DEPTH);
    pop_a  = ra && (qa.size() > 0);
    pop_b  = rb && (qb.size() > 0);
    @(posedge clk);
    if (pop_a)  void'(qa.pop_front());
    if (pop_b)  void'(qb.pop_front());
    if (push_a) qa.push_back(d);
    if (push_b) qb.push_back(d);
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    I        = '0;
    Sel      = 1'b0;
    in_valid = 1'b0;
    OA_ready = 1'b0;
    OB_ready = 1'b0;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_OA_valid", 64'(OA_valid), 64'd0);
    chk("reset_OB_valid", 64'(OB_valid), 64'd0);
    chk("reset_OA",       64'(OA),       64'd0);
    chk("reset_cnt_b",    64'(cnt_b),    64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single push into A shows up one cycle later
    applyStimulus(1'b1, 1'b0, 32'h1, 1'b0, 1'b0);
    chk("t1_OA_valid", 64'(OA_valid), 64'd1);
    chk("t1_OA",       64'(OA),       64'h1);
    chk("t1_cnt_a",    64'(cnt_a),    64'd1);
    chk("t1_OB_valid", 64'(OB_valid), 64'd0);
    chk("t1_OB",       64'(OB),       64'd0);

    // Fill B; a full B must not block A
    applyStimulus(1'b1, 1'b1, 32'hA, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hB, 1'b0, 1'b0);
    chk("t2_cnt_b", 64'(cnt_b), 64'd2);
    Sel = 1'b1; in_valid = 1'b1; I = 32'hD; OB_ready = 1'b1;
    #1;
    chk("t2_full_in_ready_with_pop", 64'(in_ready), 64'd0);
    OB_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'hD, 1'b0, 1'b0);
    chk("t2_held_cnt_b", 64'(cnt_b), 64'd2);
    Sel = 1'b0;
    #1;
    chk("t2_other_in_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 1'b0, 32'hC, 1'b0, 1'b0);
    chk("t2_cnt_a", 64'(cnt_a), 64'd2);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("t2_OA_second", 64'(OA), 64'hC);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Drain B in order
    chk("t3_OB_head", 64'(OB), 64'hA);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("t3_OB_next", 64'(OB),    64'hB);
    chk("t3_cnt_b1",  64'(cnt_b), 64'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("t3_OB_valid", 64'(OB_valid), 64'd0);
    chk("t3_OB_zero",  64'(OB),       64'd0);
    chk("t3_cnt_b0",   64'(cnt_b),    64'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("t3_no_underflow", 64'(cnt_a), 64'd0);

    // Simultaneous push and pop at occupancy 1
    applyStimulus(1'b1, 1'b0, 32'h5, 1'b0, 1'b0);
    chk("t4_OA_5", 64'(OA), 64'h5);
    applyStimulus(1'b1, 1'b0, 32'h6, 1'b1, 1'b0);
    chk("t4_cnt_a", 64'(cnt_a), 64'd1);
    chk("t4_OA_6",  64'(OA),    64'h6);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Alternating stream with both consumers always ready
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'(k % 2), 32'h10 + 32'(k), 1'b1, 1'b1);
      if (k % 2 == 0) chk("t5_OA", 64'(OA), 64'h10 + 64'(k));
      else            chk("t5_OB", 64'(OB), 64'h10 + 64'(k));
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Asynchronous reset with A full, then no stale data afterwards
    applyStimulus(1'b1, 1'b0, 32'h20, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h21, 1'b0, 1'b0);
    chk("t6_cnt_a_full", 64'(cnt_a), 64'd2);
    in_valid = 1'b0; Sel = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_OA_valid", 64'(OA_valid), 64'd0);
    chk("t6_cnt_a",    64'(cnt_a),    64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd1);
    qa.delete();
    qb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h30, 1'b0, 1'b0);
    chk("t6_first_push", 64'(OA),    64'h30);
    chk("t6_cnt_one",    64'(cnt_a), 64'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("t6_no_stale", 64'(OA_valid), 64'd0);

    // Random traffic with bursty consumer readiness
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom),
                    32'($urandom), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 2) != 0));
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
